// File: rtl/pipelined_rc_adder_pkg.sv
// pipelined_rc_adder_pkg: shared sizing helpers for the pipelined ripple-carry adder
package pipelined_rc_adder_pkg;
  function automatic int slice_width(input int width, input int stages);
    return width / stages;
  endfunction
  function automatic bit shape_ok(input int width, input int stages);
    return stages >= 1 && stages <= width && (width % stages) == 0;
  endfunction
endpackage

// File: rtl/pipelined_rc_adder_if.sv
// pipelined_rc_adder_if: operand and result streams of the pipelined adder
interface pipelined_rc_adder_if #(parameter int WIDTH = 16);
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic cin;
  logic sub;
  logic out_valid;
  logic out_ready;
  logic [WIDTH-1:0] sum;
  logic cout;
  logic ovf;
  modport master (output in_valid, a, b, cin, sub, out_ready,
                  input in_ready, out_valid, sum, cout, ovf);
  modport slave (input in_valid, a, b, cin, sub, out_ready,
                 output in_ready, out_valid, sum, cout, ovf);
endinterface

// File: rtl/pipelined_rc_adder_add_slice.sv
// add_slice: combinational ripple-carry slice built from full_adder cells
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module add_slice #(parameter int N = 4) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic ci,
  output logic [N-1:0] s,
  output logic co
);
  logic [N:0] c;
  assign c[0] = ci;
  assign co = c[N];
  for (genvar i = 0; i < N; i++) begin : g_fa
    full_adder u_fa (.a(a[i]), .b(b[i]), .ci(c[i]), .s(s[i]), .co(c[i+1]));
  end
endmodule

// File: rtl/pipelined_rc_adder.sv
// pipelined_rc_adder: add/subtract split into STAGES ripple slices with registered carries
module pipelined_rc_adder
  import pipelined_rc_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STAGES = 4
) (
  input logic clk,
  input logic rst_n,
  pipelined_rc_adder_if.slave bus
);
  localparam int SL = slice_width(WIDTH, STAGES);
  localparam int L = STAGES - 1;
  localparam bit SHAPE_OK = shape_ok(WIDTH, STAGES);
  localparam logic [WIDTH-1:0] LOW = WIDTH'({SL{1'b1}});
  if (!SHAPE_OK) begin : g_bad_shape
    $error("WIDTH must be a multiple of STAGES");
  end
  logic [STAGES-1:0] v_r, c_r, iv, ic, co, adv;
  logic [STAGES-1:0][WIDTH-1:0] s_r, pa_r, pb_r, ia, ib, ip, ns;
  logic [STAGES-1:0][SL-1:0] ss;
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign ia[k] = bus.a;
      assign ib[k] = bus.b ^ {WIDTH{bus.sub}};
      assign ic[k] = bus.cin ^ bus.sub;
      assign ip[k] = '0;
      assign iv[k] = bus.in_valid;
    end else begin : g_next
      assign ia[k] = pa_r[k-1];
      assign ib[k] = pb_r[k-1];
      assign ic[k] = c_r[k-1];
      assign ip[k] = s_r[k-1];
      assign iv[k] = v_r[k-1];
    end
    add_slice #(.N(SL)) u_slice (
      .a(ia[k][k*SL +: SL]), .b(ib[k][k*SL +: SL]), .ci(ic[k]), .s(ss[k]), .co(co[k])
    );
    // splice this stage's slice into the low bits already computed upstream
    assign ns[k] = (ip[k] & ~(LOW << (k*SL))) | (WIDTH'(ss[k]) << (k*SL));
  end
  // a stage may load when it is empty or its content moves on this edge
  always_comb begin
    logic nxt;
    nxt = bus.out_ready;
    adv = '0;
    for (int k = L; k >= 0; k--) begin
      adv[k] = !v_r[k] || nxt;
      nxt = adv[k];
    end
  end
  always_ff @(posedge clk)
    for (int k = 0; k < STAGES; k++)
      if (!rst_n) begin
        v_r[k] <= 1'b0;
        c_r[k] <= 1'b0;
        s_r[k] <= '0;
        pa_r[k] <= '0;
        pb_r[k] <= '0;
      end else if (adv[k]) begin
        v_r[k] <= iv[k];
        c_r[k] <= co[k];
        s_r[k] <= ns[k];
        pa_r[k] <= ia[k];
        pb_r[k] <= ib[k];
      end
  assign bus.in_ready = rst_n && adv[0];
  assign bus.out_valid = v_r[L];
  assign bus.sum = s_r[L];
  assign bus.cout = c_r[L];
  assign bus.ovf = (pa_r[L][WIDTH-1] == pb_r[L][WIDTH-1]) && (s_r[L][WIDTH-1] != pa_r[L][WIDTH-1]);
endmodule

// File: tb/tb_pipelined_rc_adder.sv
// tb_pipelined_rc_adder: directed vectors, stalled stream, reset and alternate-depth checks
module tb_pipelined_rc_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;

  pipelined_rc_adder_if #(.WIDTH(16)) bus ();
  pipelined_rc_adder_if #(.WIDTH(16)) b1 ();
  pipelined_rc_adder_if #(.WIDTH(16)) b16 ();
  pipelined_rc_adder #(.WIDTH(16), .STAGES(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  pipelined_rc_adder #(.WIDTH(16), .STAGES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  pipelined_rc_adder #(.WIDTH(16), .STAGES(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));

  typedef struct {
    logic [15:0] a, b;
    logic cin, sub;
    logic [15:0] s;
    logic co, ov;
  } vec_t;
  vec_t vt[9];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [17:0] model(input logic [15:0] a, b, input logic cin, sub);
    logic [15:0] bx;
    logic [16:0] r;
    bx = b ^ {16{sub}};
    r = {1'b0, a} + {1'b0, bx} + 17'(cin ^ sub);
    return {(a[15] == bx[15]) && (r[15] != a[15]), r[16], r[15:0]};
  endfunction

  initial begin
    int lat, gen, got, cyc, extra, l1, l16;
    bit pend, held;
    logic [31:0] hv;
    logic [16:0] r1, r16;
    logic [17:0] q[$];
    vt[0] = '{16'h1234, 16'h0FF1, 1'b0, 1'b0, 16'h2225, 1'b0, 1'b0};
    vt[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vt[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vt[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vt[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vt[5] = '{16'h0009, 16'h0009, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};
    vt[6] = '{16'hABCD, 16'h1234, 1'b1, 1'b0, 16'hBE02, 1'b0, 1'b0};
    vt[7] = '{16'h0005, 16'h0005, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    vt[8] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    {bus.in_valid, bus.a, bus.b, bus.cin, bus.sub} = '0;
    {b1.in_valid, b1.a, b1.b, b1.cin, b1.sub} = '0;
    {b16.in_valid, b16.a, b16.b, b16.cin, b16.sub} = '0;
    bus.out_ready = 1'b1;
    b1.out_ready = 1'b1;
    b16.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_out_valid", 32'(bus.out_valid), 0);
    check("reset_sum", 32'(bus.sum), 0);
    check("reset_in_ready", 32'(bus.in_ready), 0);
    rst_n = 1'b1;
    #1 check("release_in_ready", 32'(bus.in_ready), 1);
    @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      {bus.a, bus.b, bus.cin, bus.sub} = {vt[i].a, vt[i].b, vt[i].cin, vt[i].sub};
      bus.in_valid = 1'b1;
      #1 check($sformatf("vec%0d_in_ready", i), 32'(bus.in_ready), 1);
      lat = 0;
      do begin
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat++;
      end while (!bus.out_valid && lat < 20);
      check($sformatf("vec%0d_latency", i), lat, 4);
      check($sformatf("vec%0d_sum", i), 32'(bus.sum), 32'(vt[i].s));
      check($sformatf("vec%0d_cout", i), 32'(bus.cout), 32'(vt[i].co));
      check($sformatf("vec%0d_ovf", i), 32'(bus.ovf), 32'(vt[i].ov));
    end
    @(negedge clk);
    gen = 0; got = 0; cyc = 0; pend = 0; held = 0; hv = '0;
    while (got < 16 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (held) check("stall_hold", {13'b0, bus.out_valid, bus.ovf, bus.cout, bus.sum}, hv);
      bus.out_ready = (cyc % 4 == 1) || (cyc % 4 == 0);
      if (!pend) begin
        if (gen < 16) begin
          bus.a = 16'($urandom);
          bus.b = 16'($urandom);
          bus.cin = 1'($urandom);
          bus.sub = 1'($urandom);
          bus.in_valid = 1'b1;
          pend = 1;
          gen++;
        end else bus.in_valid = 1'b0;
      end
      #1;
      check("stream_in_ready", 32'(bus.in_ready), 32'(!(q.size() == 4 && !bus.out_ready)));
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) check("stream_extra", 32'(bus.out_valid), 0);
        else check($sformatf("stream_res%0d", got), {14'b0, bus.ovf, bus.cout, bus.sum}, 32'(q.pop_front()));
        got++;
      end
      held = bus.out_valid && !bus.out_ready;
      hv = {13'b0, bus.out_valid, bus.ovf, bus.cout, bus.sum};
      if (pend && bus.in_ready) begin
        q.push_back(model(bus.a, bus.b, bus.cin, bus.sub));
        pend = 0;
      end
    end
    check("stream_count", got, 16);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (6) @(negedge clk);
    check("stream_drained", 32'(bus.out_valid), 0);
    for (int j = 0; j < 3; j++) begin
      {bus.a, bus.b, bus.cin, bus.sub} = {16'hF0F0 + 16'(j), 16'h0F0F, 1'b1, 1'b0};
      bus.in_valid = 1'b1;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1 check("rst_in_ready", 32'(bus.in_ready), 0);
    @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_sum", 32'(bus.sum), 0);
    check("rst_cout", 32'(bus.cout), 0);
    check("rst_ovf", 32'(bus.ovf), 0);
    rst_n = 1'b1;
    {bus.a, bus.b, bus.cin, bus.sub} = {16'h1111, 16'h2222, 1'b0, 1'b0};
    bus.in_valid = 1'b1;
    #1 check("post_rst_in_ready", 32'(bus.in_ready), 1);
    lat = 0;
    do begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      lat++;
    end while (!bus.out_valid && lat < 20);
    check("post_rst_latency", lat, 4);
    check("post_rst_sum", 32'(bus.sum), 32'h3333);
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.out_valid) extra++;
    end
    check("post_rst_no_stale", extra, 0);
    {b1.a, b1.b, b1.cin, b1.sub} = {16'hFFFF, 16'h0001, 1'b0, 1'b0};
    {b16.a, b16.b, b16.cin, b16.sub} = {16'hFFFF, 16'h0001, 1'b0, 1'b0};
    b1.in_valid = 1'b1;
    b16.in_valid = 1'b1;
    l1 = 0; l16 = 0; r1 = '0; r16 = '0;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      b1.in_valid = 1'b0;
      b16.in_valid = 1'b0;
      if (b1.out_valid && l1 == 0) begin l1 = i; r1 = {b1.cout, b1.sum}; end
      if (b16.out_valid && l16 == 0) begin l16 = i; r16 = {b16.cout, b16.sum}; end
    end
    check("s1_latency", l1, 1);
    check("s1_result", 32'(r1), 32'h10000);
    check("s16_latency", l16, 16);
    check("s16_result", 32'(r16), 32'h10000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
